// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state, error-code and sync-marker definitions for the UART loader
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_ALIGN   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - parses framed bytes from a UART receiver and writes the payload words to memory
module uart_loader
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 1000000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        rx_stb_o,
    output logic        rx_cyc_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ack_i,
    output logic        mem_stb_o,
    output logic        mem_cyc_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    state_t        state_q, state_d;
    err_code_t     code_q, code_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rx_stb_q;
    logic [1:0]    byte_cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [15:0]   words_q;
    logic [7:0]    csum_q;
    logic [TW-1:0] tmo_q;

    logic          byte_ok;
    logic          timed;
    logic          tmo_hit;
    logic [31:0]   addr_next;
    logic [15:0]   len_full;

    assign byte_ok   = rx_stb_q & rx_ack_i;
    assign timed     = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign tmo_hit   = timed && !byte_ok && (tmo_q == TW'(TIMEOUT_CLKS - 1));
    // Multi-byte fields arrive LSB first, so each new byte shifts in at the top.
    assign addr_next = {rx_data_i, addr_q[31:8]};
    assign len_full  = {rx_data_i, words_q[15:8]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        if (tmo_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_ok && rx_data_i == SYNC_BYTE) begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (byte_ok && byte_cnt_q == 2'd3) begin
                        if (addr_next[1:0] != 2'b00) begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                            code_d  = ERR_ALIGN;
                        end else begin
                            state_d = ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    if (byte_ok && byte_cnt_q == 2'd1) begin
                        state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_ok && byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_i) begin
                        state_d = (words_q == 16'd1) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (byte_ok) begin
                        state_d = ST_IDLE;
                        if (rx_data_i == csum_q) begin
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            code_q     <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_stb_q   <= 1'b0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            words_q    <= 16'd0;
            csum_q     <= 8'd0;
            tmo_q      <= '0;
        end else begin
            code_q <= code_d;
            done_q <= done_d;
            err_q  <= err_d;

            // Strobe drops for at least one cycle after every accepted byte.
            if (byte_ok || tmo_hit) begin
                rx_stb_q <= 1'b0;
            end else if (!rx_stb_q && state_q != ST_WRITE) begin
                rx_stb_q <= 1'b1;
            end

            byte_cnt_q <= (state_d != state_q) ? 2'd0 : byte_cnt_q + {1'b0, byte_ok};
            tmo_q      <= (!timed || byte_ok || tmo_hit) ? '0 : tmo_q + 1'b1;

            if (byte_ok) begin
                unique case (state_q)
                    ST_IDLE: begin
                        csum_q <= 8'd0;
                    end
                    ST_ADDR: begin
                        addr_q <= addr_next;
                        csum_q <= csum_q ^ rx_data_i;
                    end
                    ST_LEN: begin
                        words_q <= len_full;
                        csum_q  <= csum_q ^ rx_data_i;
                    end
                    ST_DATA: begin
                        data_q <= {rx_data_i, data_q[31:8]};
                        csum_q <= csum_q ^ rx_data_i;
                    end
                    default: begin
                    end
                endcase
            end

            if (state_q == ST_WRITE && mem_ack_i) begin
                addr_q  <= addr_q + 32'd4;
                words_q <= words_q - 16'd1;
            end
        end
    end

    assign rx_stb_o   = rx_stb_q;
    assign rx_cyc_o   = rx_stb_q;
    assign mem_stb_o  = (state_q == ST_WRITE);
    assign mem_cyc_o  = (state_q == ST_WRITE);
    assign mem_we_o   = (state_q == ST_WRITE);
    assign mem_sel_o  = {4{state_q == ST_WRITE}};
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader: directed frame table, corner sequences, random frames
module tb_uart_loader;
    import uart_pkg::*;

    localparam int TMO = 50;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_stb_o, rx_cyc_o, rx_ack_i;
    logic [7:0]  rx_data_i;
    logic        mem_stb_o, mem_cyc_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;

    uart_loader #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_stb_o(rx_stb_o), .rx_cyc_o(rx_cyc_o), .rx_data_i(rx_data_i), .rx_ack_i(rx_ack_i),
        .mem_stb_o(mem_stb_o), .mem_cyc_o(mem_cyc_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o),
        .mem_ack_i(mem_ack_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          n_done, n_err, n_stb;
    int unsigned last_ack_edge, err_edge;
    logic        stb_at_err;
    bit          mem_hold = 1'b0;
    logic [7:0]  rx_q[$];
    logic [31:0] pay[$];
    logic [63:0] got_w[$];
    logic [63:0] exp_w[$];

    typedef struct packed {
        logic [15:0] pre;
        logic [1:0]  npre;
        logic [31:0] addr;
        logic        short_frame;
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  csum;
        logic [1:0]  exp_nw;
        logic [31:0] exp_a0;
        logic [31:0] exp_d0;
        logic [31:0] exp_a1;
        logic [31:0] exp_d1;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // UART receiver model: answers each strobe with the next queued byte after a random delay.
    initial begin
        int dly = 0;
        rx_ack_i  = 1'b0;
        rx_data_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            rx_ack_i = 1'b0;
            if (rx_stb_o && rx_q.size() > 0) begin
                if (dly == 0) begin
                    rx_data_i = rx_q.pop_front();
                    rx_ack_i  = 1'b1;
                    dly       = int'($urandom_range(0, 3));
                end else begin
                    dly--;
                end
            end
        end
    end

    // Memory model: acknowledges writes after a random delay and logs them.
    initial begin
        int dly = 0;
        mem_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_stb_o && !mem_hold) begin
                if (dly == 0) begin
                    mem_ack_i = 1'b1;
                    got_w.push_back({mem_addr_o, mem_data_o});
                    dly = int'($urandom_range(0, 3));
                end else begin
                    dly--;
                end
            end
        end
    end

    logic [63:0] prev_mem;
    bit          prev_stb = 1'b0, prev_mack = 1'b0, prev_acc = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stb = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) check("rx strobe gap", 64'(rx_stb_o), 64'd0);
            prev_acc = rx_stb_o && rx_ack_i;
            if (prev_acc) begin
                last_ack_edge = cyc + 1;
                check("rx_cyc follows rx_stb", 64'(rx_cyc_o), 64'(rx_stb_o));
            end
            if (prev_stb && prev_mack) check("mem strobe drop after ack", 64'(mem_stb_o), 64'd0);
            if (mem_stb_o) begin
                n_stb++;
                check("mem cyc/we/sel", 64'({mem_cyc_o, mem_we_o, mem_sel_o}), 64'h3F);
                if (prev_stb && !prev_mack) check("mem addr/data stable", {mem_addr_o, mem_data_o}, prev_mem);
            end
            prev_stb  = mem_stb_o;
            prev_mack = mem_ack_i;
            prev_mem  = {mem_addr_o, mem_data_o};
            if (done_o || err_o) check("done/err exclusive", 64'(done_o & err_o), 64'd0);
            if (done_o) n_done++;
            if (err_o) begin
                n_err++;
                err_edge   = cyc;
                stb_at_err = rx_stb_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        n_done = 0;
        n_err  = 0;
        n_stb  = 0;
        got_w.delete();
        exp_w.delete();
    endtask

    task automatic push_frame(input int njunk, input logic [15:0] junk, input logic [31:0] addr,
                              input bit short_frame, input logic [15:0] len, input logic [7:0] csum);
        for (int i = 0; i < njunk; i++) rx_q.push_back(junk[8*i +: 8]);
        rx_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
        if (!short_frame) begin
            rx_q.push_back(len[7:0]);
            rx_q.push_back(len[15:8]);
            foreach (pay[k]) for (int i = 0; i < 4; i++) rx_q.push_back(pay[k][8*i +: 8]);
            rx_q.push_back(csum);
        end
    endtask

    function automatic logic [7:0] model_csum(input logic [31:0] addr, input logic [15:0] len);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) x ^= addr[8*i +: 8];
        x ^= len[7:0] ^ len[15:8];
        foreach (pay[k]) for (int i = 0; i < 4; i++) x ^= pay[k][8*i +: 8];
        return x;
    endfunction

    task automatic finish_frame(input string tag, input logic [1:0] exp_code);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            #1;
            if (n_done + n_err > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " frame ended"}, 64'(ok), 64'd1);
        repeat (6) @(negedge clk_i);
        #1;
        check({tag, " done count"}, 64'(n_done), (exp_code == 2'b00) ? 64'd1 : 64'd0);
        check({tag, " err count"}, 64'(n_err), (exp_code == 2'b00) ? 64'd0 : 64'd1);
        if (exp_code != 2'b00) check({tag, " err code"}, 64'(err_code_o), 64'(exp_code));
        check({tag, " write count"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++)
            check($sformatf("%s write%0d", tag, k), got_w[k], exp_w[k]);
        if (exp_code == ERR_ALIGN) check({tag, " no mem strobe"}, 64'(n_stb), 64'd0);
        check({tag, " idle"}, 64'(busy_o), 64'd0);
        check({tag, " bytes consumed"}, 64'(rx_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [15:0] len, junk;
        logic [7:0]  cs;
        logic [1:0]  ecode;
        int          njunk;
        bit          bad, found;

        vecs[0] = '{pre: 16'h0, npre: 2'd0, addr: 32'h00001000, short_frame: 1'b0, len: 16'd2,
                    w0: 32'h44332211, w1: 32'h88776655, csum: 8'h9A, exp_nw: 2'd2,
                    exp_a0: 32'h00001000, exp_d0: 32'h44332211, exp_a1: 32'h00001004,
                    exp_d1: 32'h88776655, exp_code: 2'b00};
        vecs[1] = '{pre: 16'h0, npre: 2'd0, addr: 32'hFFFFFFFC, short_frame: 1'b0, len: 16'd2,
                    w0: 32'hDEADBEEF, w1: 32'h01234567, csum: 8'h23, exp_nw: 2'd2,
                    exp_a0: 32'hFFFFFFFC, exp_d0: 32'hDEADBEEF, exp_a1: 32'h00000000,
                    exp_d1: 32'h01234567, exp_code: 2'b00};
        vecs[2] = '{pre: 16'h0, npre: 2'd0, addr: 32'h00001002, short_frame: 1'b1, len: 16'd0,
                    w0: 32'h0, w1: 32'h0, csum: 8'h00, exp_nw: 2'd0,
                    exp_a0: 32'h0, exp_d0: 32'h0, exp_a1: 32'h0, exp_d1: 32'h0, exp_code: 2'b10};
        vecs[3] = '{pre: 16'hFF00, npre: 2'd2, addr: 32'h00000000, short_frame: 1'b0, len: 16'd0,
                    w0: 32'h0, w1: 32'h0, csum: 8'h00, exp_nw: 2'd0,
                    exp_a0: 32'h0, exp_d0: 32'h0, exp_a1: 32'h0, exp_d1: 32'h0, exp_code: 2'b00};
        vecs[4] = '{pre: 16'h0, npre: 2'd0, addr: 32'h00000040, short_frame: 1'b0, len: 16'd1,
                    w0: 32'hCAFEF00D, w1: 32'h0, csum: 8'h89, exp_nw: 2'd1,
                    exp_a0: 32'h00000040, exp_d0: 32'hCAFEF00D, exp_a1: 32'h0, exp_d1: 32'h0,
                    exp_code: 2'b01};

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("reset control outputs",
              64'({rx_stb_o, rx_cyc_o, mem_stb_o, mem_cyc_o, mem_we_o, mem_sel_o, busy_o, done_o, err_o}),
              64'd0);
        check("reset addr/data", {mem_addr_o, mem_data_o}, 64'd0);
        check("reset err code", 64'(err_code_o), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle fetch strobe", 64'(rx_stb_o), 64'd1);
        check("idle not busy", 64'(busy_o), 64'd0);

        for (int v = 0; v < 5; v++) begin
            start_frame();
            pay.delete();
            if (vecs[v].len > 16'd0) pay.push_back(vecs[v].w0);
            if (vecs[v].len > 16'd1) pay.push_back(vecs[v].w1);
            if (vecs[v].exp_nw > 2'd0) exp_w.push_back({vecs[v].exp_a0, vecs[v].exp_d0});
            if (vecs[v].exp_nw > 2'd1) exp_w.push_back({vecs[v].exp_a1, vecs[v].exp_d1});
            push_frame(int'(vecs[v].npre), vecs[v].pre, vecs[v].addr, vecs[v].short_frame,
                       vecs[v].len, vecs[v].csum);
            finish_frame($sformatf("vec%0d", v), vecs[v].exp_code);
        end

        // Byte stream stops after LEN: timeout must fire a fixed distance after the last ack.
        start_frame();
        pay.delete();
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h00); rx_q.push_back(8'h01); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        rx_q.push_back(8'h01); rx_q.push_back(8'h00);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            #1;
            if (n_err > 0) begin
                found = 1'b1;
                break;
            end
        end
        check("timeout fired", 64'(found), 64'd1);
        check("timeout distance", 64'(err_edge - last_ack_edge), 64'(TMO));
        check("timeout code", 64'(err_code_o), 64'(ERR_TIMEOUT));
        check("timeout drops rx strobe", 64'(stb_at_err), 64'd0);
        repeat (3) @(negedge clk_i);
        check("timeout back to idle", 64'(busy_o), 64'd0);
        check("timeout no writes", 64'(got_w.size()), 64'd0);

        // Reset asserted while a write is waiting for its ack.
        start_frame();
        mem_hold = 1'b1;
        pay.delete();
        pay.push_back(32'h12345678);
        push_frame(0, 16'h0, 32'h00000200, 1'b0, 16'd1, model_csum(32'h00000200, 16'd1));
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (mem_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        check("write reached before reset", 64'(found), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("reset drops mem strobe", 64'({mem_stb_o, mem_cyc_o, mem_we_o, mem_sel_o}), 64'd0);
        check("reset clears busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rx_q.delete();
        mem_hold = 1'b0;
        check("reset write not acked", 64'(got_w.size()), 64'd0);
        repeat (2) @(negedge clk_i);

        for (int r = 0; r < 20; r++) begin
            start_frame();
            pay.delete();
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFF8;
            len = 16'($urandom_range(0, 3));
            for (int k = 0; k < int'(len); k++) pay.push_back($urandom);
            bad = ($urandom_range(0, 3) == 0);
            cs = model_csum(a, len) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
            njunk = int'($urandom_range(0, 2));
            junk = 16'($urandom);
            for (int i = 0; i < 2; i++) if (junk[8*i +: 8] == 8'hA5) junk[8*i +: 8] = 8'h5A;
            if (a[1:0] != 2'b00) begin
                ecode = ERR_ALIGN;
                push_frame(njunk, junk, a, 1'b1, len, cs);
            end else begin
                ecode = bad ? ERR_CSUM : ERR_NONE;
                foreach (pay[k]) exp_w.push_back({a + 32'(4 * k), pay[k]});
                push_frame(njunk, junk, a, 1'b0, len, cs);
            end
            finish_frame($sformatf("rand%0d", r), ecode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
